// File: rtl/cell_pos_reader_if.sv
// Memory-port and position-stream signals for cell_pos_reader.
// master = the reader; slave = memory plus stream consumer.
interface cell_pos_reader_if #(
  parameter int unsigned DATA_WIDTH = 96,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] ram_address;
  logic                  ram_rden;
  logic                  ram_wren;
  logic [DATA_WIDTH-1:0] ram_data;
  logic [DATA_WIDTH-1:0] ram_q;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_index;
  logic                  out_last;

  modport master (
    output ram_address, ram_rden, ram_wren, ram_data,
    input  ram_q,
    output out_valid, out_data, out_index, out_last,
    input  out_ready
  );

  modport slave (
    input  ram_address, ram_rden, ram_wren, ram_data,
    output ram_q,
    input  out_valid, out_data, out_index, out_last,
    output out_ready
  );
endinterface

// File: rtl/cell_pos_reader.sv
// Reads the particle count of one cell memory, then streams every position out
// through a 4-entry FIFO with credit-based read issue so no return is ever dropped.
module cell_pos_reader #(
  parameter int unsigned DATA_WIDTH   = 96,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned PARTICLE_NUM = 220
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] particle_count_o,
  output logic                  count_err_o,
  cell_pos_reader_if.master     bus
);

  localparam logic [ADDR_WIDTH-1:0] MaxCount = ADDR_WIDTH'(PARTICLE_NUM - 1);
  localparam int unsigned FifoDepth = 4;

  typedef enum logic [2:0] {
    StIdle,
    StCntReq,
    StCntWait,
    StStream,
    StDrain,
    StDone
  } state_e;

  state_e                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] count_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rden_q;

  // Request tag pipeline: stage 2 lines up with the returning memory word.
  logic                  s1_vld_q, s2_vld_q;
  logic [ADDR_WIDTH-1:0] s1_idx_q, s2_idx_q;
  logic                  s1_last_q, s2_last_q;

  logic [DATA_WIDTH-1:0] fifo_data_q [FifoDepth];
  logic [ADDR_WIDTH-1:0] fifo_idx_q  [FifoDepth];
  logic                  fifo_last_q [FifoDepth];
  logic [1:0]            wr_ptr_q, rd_ptr_q;
  logic [2:0]            occ_q;

  logic                  push;
  logic                  pop;
  logic [2:0]            inflight;
  logic                  credit_ok;
  logic                  drain_done;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] raw_count;
  logic                  count_over;
  logic [ADDR_WIDTH-1:0] clamped_count;

  always_comb begin
    pop           = (occ_q != 3'd0) && bus.out_ready;
    // The only return seen while waiting for the count is the count word itself.
    push          = s2_vld_q && (state_q != StCntWait);
    inflight      = {2'b00, rden_q} + {2'b00, s1_vld_q} + {2'b00, s2_vld_q};
    // Counting the same-cycle pop keeps issue at one read per cycle without overflow.
    credit_ok     = ({1'b0, occ_q} + {1'b0, inflight}) < (4'd4 + {3'b000, pop});
    drain_done    = (inflight == 3'd0) &&
                    ((occ_q == 3'd0) || ((occ_q == 3'd1) && pop));
    next_addr     = addr_q + ADDR_WIDTH'(1);
    raw_count     = bus.ram_q[ADDR_WIDTH-1:0];
    count_over    = raw_count > MaxCount;
    clamped_count = count_over ? MaxCount : raw_count;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
      addr_q  <= '0;
      rden_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      rden_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q <= StCntReq;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            rden_q  <= 1'b1;
            addr_q  <= '0;
          end
        end
        StCntReq: state_q <= StCntWait;
        StCntWait: begin
          if (s2_vld_q) begin
            count_q <= clamped_count;
            err_q   <= count_over;
            if (clamped_count == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              rden_q  <= 1'b1;
              addr_q  <= ADDR_WIDTH'(1);
              state_q <= (clamped_count == ADDR_WIDTH'(1)) ? StDrain : StStream;
            end
          end
        end
        StStream: begin
          if (credit_ok) begin
            rden_q <= 1'b1;
            addr_q <= next_addr;
            if (next_addr == count_q) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (drain_done) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_idx_q  <= '0;
      s1_last_q <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_idx_q  <= '0;
      s2_last_q <= 1'b0;
    end else begin
      s1_vld_q  <= rden_q;
      s1_idx_q  <= addr_q;
      s1_last_q <= (addr_q == count_q);
      s2_vld_q  <= s1_vld_q;
      s2_idx_q  <= s1_idx_q;
      s2_last_q <= s1_last_q;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FifoDepth; i++) begin
        fifo_data_q[i] <= '0;
        fifo_idx_q[i]  <= '0;
        fifo_last_q[i] <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= bus.ram_q;
        fifo_idx_q[wr_ptr_q]  <= s2_idx_q;
        fifo_last_q[wr_ptr_q] <= s2_last_q;
        wr_ptr_q              <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      occ_q <= occ_q + {2'b00, push} - {2'b00, pop};
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign particle_count_o = count_q;
  assign count_err_o      = err_q;

  assign bus.ram_address = addr_q;
  assign bus.ram_rden    = rden_q;
  assign bus.ram_wren    = 1'b0;
  assign bus.ram_data    = '0;

  assign bus.out_valid = (occ_q != 3'd0);
  assign bus.out_data  = fifo_data_q[rd_ptr_q];
  assign bus.out_index = fifo_idx_q[rd_ptr_q];
  assign bus.out_last  = fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_cell_pos_reader.sv
// Directed bench for cell_pos_reader: a 2-cycle memory model, a negedge event
// logger, and a linear sequence of scenarios checked with immediate assertions.
module tb_cell_pos_reader;

  logic       clock;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] particle_count;
  logic       count_err;

  cell_pos_reader_if #(.DATA_WIDTH(96), .ADDR_WIDTH(8)) bus ();

  cell_pos_reader #(
    .DATA_WIDTH  (96),
    .ADDR_WIDTH  (8),
    .PARTICLE_NUM(220)
  ) dut (
    .clock           (clock),
    .rst_n           (rst_n),
    .start_i         (start),
    .busy_o          (busy),
    .done_o          (done),
    .particle_count_o(particle_count),
    .count_err_o     (count_err),
    .bus             (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Memory model: address/rden in cycle t -> data on ram_q in cycle t+2.
  logic [95:0] mem [0:255];
  logic [95:0] ram_r1;
  always @(posedge clock) begin
    if (bus.ram_rden) ram_r1 <= mem[bus.ram_address];
    bus.ram_q <= ram_r1;
  end

  int          n_rd = 0, n_pop = 0, n_done = 0;
  int          rd_cyc [1024];
  int          rd_addr[1024];
  int          pop_cyc[1024];
  int          pop_idx[1024];
  logic [95:0] pop_dat[1024];
  logic        pop_lst[1024];
  int          done_cyc[64];

  always @(negedge clock) begin
    if (rst_n) begin
      if (bus.ram_rden) begin
        rd_cyc[n_rd]  = cyc;
        rd_addr[n_rd] = int'(bus.ram_address);
        n_rd++;
      end
      if (bus.out_valid && bus.out_ready) begin
        pop_cyc[n_pop] = cyc;
        pop_idx[n_pop] = int'(bus.out_index);
        pop_dat[n_pop] = bus.out_data;
        pop_lst[n_pop] = bus.out_last;
        n_pop++;
      end
      if (done) begin
        done_cyc[n_done] = cyc;
        n_done++;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int t0, rd_base, pop_base, done_base;

  function automatic logic [95:0] pos(input int i);
    return {32'hABCD0000 + 32'(i), 32'h00001000 + 32'(i), 32'(i)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_start();
    @(posedge clock); #1;
    start     = 1'b1;
    t0        = cyc;
    rd_base   = n_rd;
    pop_base  = n_pop;
    done_base = n_done;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_rel(input int r);
    while (cyc - t0 < r) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic wait_done(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (n_done > done_base) break;
      @(posedge clock); #1;
    end
    chk("done_seen", 128'(n_done > done_base), 128'd1);
  endtask

  // Checks popped words pop_base.. against indices 1..n with last on n.
  task automatic chk_stream(input string tag, input int n);
    chk({tag, "_npop"}, 128'(n_pop - pop_base), 128'(n));
    for (int i = 0; i < n; i++) begin
      chk({tag, "_idx"}, 128'(pop_idx[pop_base+i]), 128'(i + 1));
      chk({tag, "_data"}, 128'(pop_dat[pop_base+i]), 128'(pos(i + 1)));
      chk({tag, "_last"}, 128'(pop_lst[pop_base+i]), 128'(i == n - 1));
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 1; i < 256; i++) mem[i] = pos(i);
    mem[0] = 96'd3;
    repeat (3) @(posedge clock);
    #1;

    // Reset values.
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_last", 128'(bus.out_last), 128'd0);
    chk("rst_rden", 128'(bus.ram_rden), 128'd0);
    chk("rst_err", 128'(count_err), 128'd0);
    chk("rst_addr", 128'(bus.ram_address), 128'd0);
    chk("rst_pcount", 128'(particle_count), 128'd0);
    chk("rst_index", 128'(bus.out_index), 128'd0);
    chk("rst_data", 128'(bus.out_data), 128'd0);
    chk("rst_wren", 128'(bus.ram_wren), 128'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // Count 3, consumer always ready: exact cycle timing.
    run_start();
    chk("c3_busy", 128'(busy), 128'd1);
    wait_done(40);
    chk("c3_nrd", 128'(n_rd - rd_base), 128'd4);
    chk("c3_rd0_cyc", 128'(rd_cyc[rd_base+0] - t0), 128'd1);
    chk("c3_rd0_adr", 128'(rd_addr[rd_base+0]), 128'd0);
    chk("c3_rd1_cyc", 128'(rd_cyc[rd_base+1] - t0), 128'd4);
    chk("c3_rd1_adr", 128'(rd_addr[rd_base+1]), 128'd1);
    chk("c3_rd2_cyc", 128'(rd_cyc[rd_base+2] - t0), 128'd5);
    chk("c3_rd3_cyc", 128'(rd_cyc[rd_base+3] - t0), 128'd6);
    chk("c3_rd3_adr", 128'(rd_addr[rd_base+3]), 128'd3);
    chk_stream("c3", 3);
    chk("c3_pop0_cyc", 128'(pop_cyc[pop_base+0] - t0), 128'd7);
    chk("c3_pop1_cyc", 128'(pop_cyc[pop_base+1] - t0), 128'd8);
    chk("c3_pop2_cyc", 128'(pop_cyc[pop_base+2] - t0), 128'd9);
    chk("c3_done_cyc", 128'(done_cyc[done_base] - t0), 128'd10);
    chk("c3_pcount", 128'(particle_count), 128'd3);
    @(posedge clock); #1;
    chk("c3_idle", 128'(busy), 128'd0);

    // Count 0: done in cycle 4, nothing streamed.
    mem[0] = 96'd0;
    run_start();
    wait_done(40);
    chk("c0_done_cyc", 128'(done_cyc[done_base] - t0), 128'd4);
    repeat (4) @(posedge clock);
    #1;
    chk("c0_npop", 128'(n_pop - pop_base), 128'd0);
    chk("c0_pcount", 128'(particle_count), 128'd0);
    chk("c0_nrd", 128'(n_rd - rd_base), 128'd1);

    // Count 10, consumer stalled for cycles 0..30.
    mem[0] = 96'd10;
    bus.out_ready = 1'b0;
    run_start();
    wait_rel(31);
    chk("c10_stall_valid", 128'(bus.out_valid), 128'd1);
    chk("c10_stall_nrd", 128'(n_rd - rd_base), 128'd5);
    bus.out_ready = 1'b1;
    wait_done(80);
    chk("c10_first_pop", 128'(pop_cyc[pop_base] - t0), 128'd31);
    chk_stream("c10", 10);

    // Over-range count is clamped and flagged.
    mem[0] = 96'd250;
    run_start();
    wait_done(400);
    chk("cl_pcount", 128'(particle_count), 128'd219);
    chk("cl_err", 128'(count_err), 128'd1);
    chk_stream("cl", 219);
    repeat (2) @(posedge clock);
    #1;
    chk("cl_err_held", 128'(count_err), 128'd1);

    // Second start during an active read is ignored; count_err clears on start.
    mem[0] = 96'd3;
    run_start();
    chk("rs_err_clr", 128'(count_err), 128'd0);
    wait_rel(5);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(40);
    chk("rs_done_cyc", 128'(done_cyc[done_base] - t0), 128'd10);
    repeat (20) @(posedge clock);
    #1;
    chk("rs_ndone", 128'(n_done - done_base), 128'd1);
    chk_stream("rs", 3);
    chk("rs_pop0_cyc", 128'(pop_cyc[pop_base] - t0), 128'd7);

    // Reset during STREAM with two reads outstanding.
    mem[0] = 96'd10;
    run_start();
    wait_rel(5);
    chk("mr_pre_rden", 128'(bus.ram_rden), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_busy", 128'(busy), 128'd0);
    chk("mr_rden", 128'(bus.ram_rden), 128'd0);
    chk("mr_addr", 128'(bus.ram_address), 128'd0);
    chk("mr_valid", 128'(bus.out_valid), 128'd0);
    chk("mr_pcount", 128'(particle_count), 128'd0);
    chk("mr_index", 128'(bus.out_index), 128'd0);
    chk("mr_data", 128'(bus.out_data), 128'd0);
    @(posedge clock); #1;
    rst_n = 1'b1;
    pop_base = n_pop;
    repeat (6) @(posedge clock);
    #1;
    chk("mr_no_stale", 128'(n_pop - pop_base), 128'd0);
    chk("mr_idle", 128'(busy), 128'd0);
    mem[0] = 96'd4;
    run_start();
    wait_done(40);
    chk_stream("mr", 4);
    chk("mr_done_cyc", 128'(done_cyc[done_base] - t0), 128'd11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
